bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
- Parallel-to-serial front end that drives the single-bit `din` input of the sequence detector, one bit per clock.
- Accepts a word of up to WIDTH bits over a valid/ready handshake.
- Shifts the word out MSB-first with a per-bit valid flag.
- Supports back-to-back words with no idle gap, so the detector sees a continuous bitstream.

Parameters:
- WIDTH, 20, maximum word length in bits (≥2).
- LEN_W, $clog2(WIDTH+1), width of the in_len field.
- IDLE_BIT, 1'b0, level driven on dout when no bit is being presented.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous reset, active-low (asserted when 0, sampled on posedge clk).
- in_data  input  WIDTH  word to serialize; bit [in_len-1] goes out first.
- in_len  input  LEN_W  number of bits to send. 0 or >WIDTH means WIDTH.
- in_valid  input  1  in_data/in_len valid.
- in_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial bit; connects to detector din.
- dout_valid  output  1  dout carries a real bit this cycle.
- done  output  1  one-cycle pulse with the last bit of a word.
- busy  output  1  high while in SHIFT.

Behaviour:
- State machine: IDLE, SHIFT. Registers: shift register sh[WIDTH-1:0], remaining-bit counter cnt[LEN_W-1:0], saved word/len (used by the optional feature).
- Reset (rst==0 at posedge):
  - state=IDLE, sh=0, cnt=0.
  - Outputs: dout=IDLE_BIT, dout_valid=0, done=0, busy=0.
  - Reset overrides everything, including an accept in the same cycle. A word in flight is discarded with no done pulse.
- in_ready is combinational: 1 in IDLE, or in SHIFT when cnt==1 (last bit presented). Otherwise 0. in_ready=0 while rst==0.
- Accept = in_valid & in_ready at posedge.
  - Effective length L = (in_len==0 || in_len>WIDTH) ? WIDTH : in_len.
  - Word is left-aligned: sh = in_data << (WIDTH-L).
  - cnt=L, state=SHIFT.
- Output timing:
  - dout, dout_valid, done and busy are registered.
  - dout = sh[WIDTH-1], valid from the cycle after accept. Latency is one clock from accept to first bit.
  - Each posedge in SHIFT without a new accept: sh<<=1 with 0 fill, cnt-=1.
- done=1 exactly in the cycle where dout_valid=1 and cnt==1.
- Last bit, no accept: next cycle state=IDLE, dout_valid=0, dout=IDLE_BIT, busy=0.
- Last bit with accept (back-to-back): the new word's MSB appears in the very next cycle. dout_valid stays 1 continuously with no bubble.
- in_valid while in_ready=0: ignored, no state change. The source must hold it.
- L==1: one cycle of dout_valid, with done high in that same cycle.
- In IDLE, dout holds IDLE_BIT irrespective of in_data.

Optional Feature:
- Macro: SER_LOOP_EN
- When defined:
  - An extra input port `loop` (1 bit) exists.
  - If loop==1 at the last bit and no new word is accepted, the saved word/length reloads and retransmission starts the next cycle without a bubble. done still pulses at each repetition's last bit.
  - A new accept at the last bit takes priority over the reload.
  - Deasserting loop lets the current repetition finish, then the block goes to IDLE.
- When undefined: no `loop` port, and the saved-word registers are not instantiated. Behaviour is exactly as above.

Test Plan:
- Reset mid-word: load 8'hA5, L=8, drive rst=0 at the 3rd bit -> next cycle dout_valid=0, dout=IDLE_BIT, in_ready=1, no done pulse. Reload of 8'h3C afterwards serializes 0,0,1,1,1,1,0,0.
- Full word: rst=1, load in_data=20'b00110011011010011010, in_len=20 -> starting 1 cycle later, dout over 20 consecutive cycles = 0,0,1,1,0,0,1,1,0,1,1,0,1,0,0,1,1,0,1,0. dout_valid=1 for all 20 cycles, done only on the 20th, then dout_valid=0.
- Back-to-back: word A=4'b1011 (L=4), hold in_valid with B=3'b010 (L=3) -> 7 contiguous valid bits 1,0,1,1,0,1,0. B is accepted on A's last bit, and done pulses on bits 4 and 7.
- Length edge cases:
  - in_len=0 with in_data=20'hFFFFF -> 20 ones.
  - in_len=1 with in_data=1 -> a single bit 1, with done and dout_valid high in the same cycle and in_ready=1 during it.
- Stall: raise in_valid at bit 2 of a 6-bit word -> in_ready=0 until bit 6, acceptance happens at bit 6, and the in_data change at bit 3 does not corrupt the word in flight.
- (SER_LOOP_EN) loop=1, load 3'b110 -> output 1,1,0,1,1,0,… with done every 3rd cycle. Drop loop mid-repetition -> that repetition completes, then IDLE.

Source files
------------

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bus of bit_serializer: the source drives the word side, the
// serializer drives the serial side plus in_ready.
interface bit_serializer_if #(
    parameter int WIDTH = 20,
    parameter int LEN_W = $clog2(WIDTH + 1)
);
    logic [WIDTH-1:0] in_data;
    logic [LEN_W-1:0] in_len;
    logic             in_valid;
    logic             in_ready;
    logic             dout;
    logic             dout_valid;
    logic             done;
    logic             busy;

    modport master (
        output in_data, in_len, in_valid,
        input  in_ready, dout, dout_valid, done, busy
    );

    modport slave (
        input  in_data, in_len, in_valid,
        output in_ready, dout, dout_valid, done, busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: MSB-first, one bit per clock, gapless back-to-back words.
// Optional SER_LOOP_EN adds a `loop` input that retransmits the last accepted word.
module bit_serializer #(
    parameter int   WIDTH    = 20,
    parameter int   LEN_W    = $clog2(WIDTH + 1),
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
`ifdef SER_LOOP_EN
    input  logic loop,
`endif
    bit_serializer_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [LEN_W-1:0] WMAX = LEN_W'(WIDTH);

    state_t           state, state_nx;
    logic [WIDTH-1:0] sh, sh_nx, ld_sh;
    logic [LEN_W-1:0] cnt, cnt_nx, ld_len;
    logic             last, accept;
    logic             dout_r, vld_r, done_r, busy_r;

    // cnt counts bits still to present, including the one on dout now.
    assign last         = (state == SHIFT) && (cnt == LEN_W'(1));
    assign bus.in_ready = rst && ((state == IDLE) || last);
    assign accept       = bus.in_valid && bus.in_ready;

    assign ld_len = ((bus.in_len == '0) || (bus.in_len > WMAX)) ? WMAX : bus.in_len;
    assign ld_sh  = bus.in_data << (WMAX - ld_len);

`ifdef SER_LOOP_EN
    logic [WIDTH-1:0] sv_sh;
    logic [LEN_W-1:0] sv_len;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sv_sh  <= '0;
            sv_len <= '0;
        end else if (accept) begin
            sv_sh  <= ld_sh;
            sv_len <= ld_len;
        end
    end
`endif

    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        cnt_nx   = cnt;
        if (accept) begin
            state_nx = SHIFT;
            sh_nx    = ld_sh;
            cnt_nx   = ld_len;
        end else if (last) begin
            state_nx = IDLE;
            sh_nx    = sh << 1;
            cnt_nx   = '0;
`ifdef SER_LOOP_EN
            if (loop) begin
                state_nx = SHIFT;
                sh_nx    = sv_sh;
                cnt_nx   = sv_len;
            end
`endif
        end else if (state == SHIFT) begin
            sh_nx  = sh << 1;
            cnt_nx = cnt - LEN_W'(1);
        end
    end

    // Outputs are registered from next-state so the first bit lands one clock after accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            sh     <= '0;
            cnt    <= '0;
            dout_r <= IDLE_BIT;
            vld_r  <= 1'b0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            state  <= state_nx;
            sh     <= sh_nx;
            cnt    <= cnt_nx;
            dout_r <= (state_nx == SHIFT) ? sh_nx[WIDTH-1] : IDLE_BIT;
            vld_r  <= (state_nx == SHIFT);
            busy_r <= (state_nx == SHIFT);
            done_r <= (state_nx == SHIFT) && (cnt_nx == LEN_W'(1));
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = vld_r;
    assign bus.done       = done_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: a queue-of-bits reference model checked every cycle,
// directed streams pinned to literal bit patterns, then randomized traffic.
module tb_bit_serializer;
    localparam int WIDTH = 20;
    localparam int LEN_W = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic loop = 1'b0;

    bit_serializer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

    bit_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .IDLE_BIT(1'b0)) dut (
        .clk (clk),
        .rst (rst),
`ifdef SER_LOOP_EN
        .loop(loop),
`endif
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic last;
    } sbit_t;

    sbit_t q[$];
    logic [WIDTH-1:0] sv_data;
    int               sv_len;
    bit               started = 0;
    int               checks = 0;
    int               errors = 0;
    logic             cap_b[$];
    logic             cap_d[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int eff_len(input int l);
        return (l == 0 || l > WIDTH) ? WIDTH : l;
    endfunction

    function automatic void push_word(input logic [WIDTH-1:0] d, input int l);
        for (int i = l - 1; i >= 0; i--) q.push_back('{b: d[i], last: (i == 0)});
    endfunction

    // Model: the queue holds every bit still owed, front = bit on dout now.
    always @(posedge clk) begin
        bit acc, was_last;
        started <= 1;
        if (!rst) begin
            q.delete();
        end else begin
            acc      = bus.in_valid && (q.size() <= 1);
            was_last = (q.size() == 1);
            if (q.size() > 0) void'(q.pop_front());
            if (acc) begin
                sv_data = bus.in_data;
                sv_len  = eff_len(int'(bus.in_len));
                push_word(sv_data, sv_len);
            end else if (was_last && loop) begin
                push_word(sv_data, sv_len);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit v;
            v = (q.size() > 0);
            chk("dout_valid", bus.dout_valid, v);
            chk("busy", bus.busy, v);
            chk("in_ready", bus.in_ready, rst && (q.size() <= 1));
            chk("dout", bus.dout, v ? q[0].b : 1'b0);
            chk("done", bus.done, v ? q[0].last : 1'b0);
            if (bus.dout_valid === 1'b1) begin
                cap_b.push_back(bus.dout);
                cap_d.push_back(bus.done);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input int l, input bit scramble);
        int t = 0;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && t < 100) begin
            bus.in_data = scramble ? WIDTH'($urandom) : d;
            bus.in_len  = scramble ? LEN_W'($urandom) : LEN_W'(l);
            step();
            t++;
        end
        if (t >= 100) chk("send_timeout", 1, 0);
        bus.in_data = d;
        bus.in_len  = LEN_W'(l);
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = WIDTH'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) chk("idle_timeout", 1, 0);
        step();
    endtask

    task automatic clr_cap();
        cap_b.delete();
        cap_d.delete();
    endtask

    // Compares the first n captured bits against literals written MSB = first bit.
    task automatic chk_cap(input string name, input logic [31:0] eb, input logic [31:0] ed, input int n);
        chk({name, "_len"}, cap_b.size() >= n, 1);
        for (int i = 0; i < n && i < cap_b.size(); i++) begin
            chk({name, "_bit"}, cap_b[i], eb[n-1-i]);
            chk({name, "_done"}, cap_d[i], ed[n-1-i]);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_len   = '0;
        step();
        step();
        chk("rst_dout_valid", bus.dout_valid, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        rst = 1'b1;
        step();
        chk("idle_in_ready", bus.in_ready, 1);

        // Reset in the middle of a word, then a clean reload.
        clr_cap();
        send(20'hA5, 8, 0);
        while (cap_b.size() < 3) step();
        rst = 1'b0;
        step();
        chk("midrst_valid", bus.dout_valid, 0);
        chk("midrst_done", bus.done, 0);
        rst = 1'b1;
        #1;
        chk("midrst_ready", bus.in_ready, 1);
        chk_cap("midrst_prefix", 32'b101, 32'b000, 3);
        chk("midrst_count", cap_b.size(), 3);
        clr_cap();
        send(20'h3C, 8, 0);
        wait_idle();
        chk_cap("reload", 32'b00111100, 32'b00000001, 8);

        clr_cap();
        send(20'b00110011011010011010, 20, 0);
        wait_idle();
        chk_cap("full", 32'b00110011011010011010, 32'b00000000000000000001, 20);
        chk("full_count", cap_b.size(), 20);

        clr_cap();
        send(20'b1011, 4, 0);
        send(20'b010, 3, 0);
        wait_idle();
        chk_cap("b2b", 32'b1011010, 32'b0001001, 7);

        clr_cap();
        send(20'hFFFFF, 0, 0);
        wait_idle();
        chk_cap("len0", 32'hFFFFF, 32'h00001, 20);

        clr_cap();
        send(20'h1, 1, 0);
        chk("len1_ready", bus.in_ready, 1);
        wait_idle();
        chk_cap("len1", 32'b1, 32'b1, 1);
        chk("len1_count", cap_b.size(), 1);

        // Stall: second word raised at bit 2, garbage on the bus until in_ready.
        clr_cap();
        send(20'b101101, 6, 0);
        send(20'b0110, 4, 1);
        wait_idle();
        chk_cap("stall", 32'b1011010110, 32'b0000010001, 10);

`ifdef SER_LOOP_EN
        clr_cap();
        loop = 1'b1;
        send(20'b110, 3, 0);
        while (cap_b.size() < 10) step();
        loop = 1'b0;
        wait_idle();
        chk_cap("loop", 32'b110110110, 32'b001001001, 9);
        chk("loop_count", cap_b.size(), 12);
`endif

        for (int n = 0; n < 300; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step();
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b0;
                step();
                rst = 1'b1;
            end
`ifdef SER_LOOP_EN
            loop = ($urandom_range(0, 5) == 0);
`endif
            send(WIDTH'($urandom), $urandom_range(0, 31), $urandom_range(0, 1));
        end
        loop = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
